// File: rtl/i2s_link.sv
// ---------------------------------------------------------------------------
// i2s_link -- I2S master link to an audio codec.
//
// Generates the codec clocks from a 9-bit free-running frame counter
// (MCLK = clk24/2, BCK = clk24/8, LRCK = clk24/512). It serializes a
// stereo 16-bit DAC sample pair, MSB first, with the one-BCK I2S delay.
// Optionally it captures the left-channel ADC word from the codec.
//
// Optional feature macro: I2S_ADC_EN
//   When defined, the ADC capture path is built.
//   When undefined, o_linein / o_linein_valid are tied to 0 and
//   i_adcdat is ignored.
//
// Ports
//   clk24          in   1   24 MHz system clock, rising edge
//   reset          in   1   synchronous, active-high reset
//   i_sample_l     in  16   left DAC sample (two's complement)
//   i_sample_r     in  16   right DAC sample (two's complement)
//   o_sample_req   out  1   high while cnt=511; inputs latched on this cycle
//   o_mclk         out  1   codec master clock (cnt[0])
//   o_bck          out  1   bit clock (cnt[2])
//   o_lrck         out  1   word select, 0 = left, 1 = right (cnt[8])
//   o_dacdat       out  1   serial DAC data
//   i_adcdat       in   1   serial ADC data
//   o_linein       out 16   last captured left ADC word
//   o_linein_valid out  1   high for the one cycle at cnt=136
// ---------------------------------------------------------------------------
module i2s_link (
    input  logic        clk24,
    input  logic        reset,
    input  logic [15:0] i_sample_l,
    input  logic [15:0] i_sample_r,
    output logic        o_sample_req,
    output logic        o_mclk,
    output logic        o_bck,
    output logic        o_lrck,
    output logic        o_dacdat,
    input  logic        i_adcdat,
    output logic [15:0] o_linein,
    output logic        o_linein_valid
);

    logic [8:0]  cnt_r;
    logic [8:0]  cnt_nxt_s;
    logic [15:0] shadow_l_r;
    logic [15:0] shadow_r_r;
    logic        dac_r;
    logic        dac_nxt_s;
    logic        sample_req_r;

    // Serial bit for a slot: slots 1..16 carry word bits 15..0 (one-BCK
    // I2S delay); slot 0 and slots 17..31 are padded with zeros.
    function automatic logic dac_bit(input logic [15:0] word, input logic [4:0] slot);
        logic [3:0] idx;
        if ((slot >= 5'd1) && (slot <= 5'd16)) begin
            idx     = 4'(5'd16 - slot);
            dac_bit = word[idx];
        end else begin
            idx     = 4'd0;
            dac_bit = 1'b0;
        end
    endfunction

    // Next counter value and the DAC bit for the slot it starts.
    // dac_r is loaded one cycle before that slot begins, so the new bit
    // appears together with the BCK falling edge.
    always_comb begin
        cnt_nxt_s = cnt_r + 9'd1;
        dac_nxt_s = dac_bit(cnt_nxt_s[8] ? shadow_r_r : shadow_l_r, cnt_nxt_s[7:3]);
    end

    // Frame counter, input shadows, DAC shift-out and the sample request.
    always_ff @(posedge clk24) begin
        if (reset) begin
            cnt_r        <= 9'd0;
            shadow_l_r   <= 16'd0;
            shadow_r_r   <= 16'd0;
            dac_r        <= 1'b0;
            sample_req_r <= 1'b0;
        end else begin
            cnt_r        <= cnt_nxt_s;
            // Registered one cycle early so that it is high exactly while cnt=511.
            sample_req_r <= (cnt_r == 9'd510);
            if (cnt_r == 9'd511) begin
                shadow_l_r <= i_sample_l;
                shadow_r_r <= i_sample_r;
            end
            if (cnt_r[2:0] == 3'd7) begin
                dac_r <= dac_nxt_s;
            end
        end
    end

    assign o_mclk       = cnt_r[0];
    assign o_bck        = cnt_r[2];
    assign o_lrck       = cnt_r[8];
    assign o_dacdat     = dac_r;
    assign o_sample_req = sample_req_r;

`ifdef I2S_ADC_EN
    logic [15:0] adc_shift_r;
    logic [15:0] linein_r;
    logic        linein_valid_r;
    logic        adc_take_s;

    // Sample on the BCK rising edge (cnt[2:0]=3 -> 4) in left slots 1..16.
    always_comb begin
        adc_take_s = (cnt_r[8] == 1'b0) && (cnt_r[2:0] == 3'd3) &&
                     (cnt_r[7:3] >= 5'd1) && (cnt_r[7:3] <= 5'd16);
    end

    // ADC shift register and word transfer. The last bit is taken at
    // cnt=131, so the transfer at cnt=135 always sees a complete word.
    always_ff @(posedge clk24) begin
        if (reset) begin
            adc_shift_r    <= 16'd0;
            linein_r       <= 16'd0;
            linein_valid_r <= 1'b0;
        end else begin
            if (adc_take_s) begin
                adc_shift_r <= {adc_shift_r[14:0], i_adcdat};
            end
            if (cnt_r == 9'd135) begin
                linein_r <= adc_shift_r;
            end
            linein_valid_r <= (cnt_r == 9'd135);
        end
    end

    assign o_linein       = linein_r;
    assign o_linein_valid = linein_valid_r;
`else
    logic unused_adcdat_s;

    assign unused_adcdat_s = i_adcdat;
    assign o_linein        = 16'd0;
    assign o_linein_valid  = 1'b0;
`endif

endmodule

// File: doc/i2s_link.md
I2S_LINK -- requirements
Module: i2s_link

Interface
REQ-001 SHALL have port: clk24  input  1  system clock, 24 MHz; all logic on its rising edge.
REQ-002 SHALL have port: reset  input  1  reset; synchronous and active-high.
REQ-003 SHALL have port: i_sample_l  input  16  left DAC sample, two's complement.
REQ-004 SHALL have port: i_sample_r  input  16  right DAC sample, two's complement.
REQ-005 SHALL have port: o_sample_req  output  1  one-cycle strobe; the inputs are latched on this cycle.
REQ-006 SHALL have port: o_mclk  output  1  codec master clock, clk24/2.
REQ-007 SHALL have port: o_bck  output  1  bit clock, clk24/8.
REQ-008 SHALL have port: o_lrck  output  1  word select; 0 = left, 1 = right.
REQ-009 SHALL have port: o_dacdat  output  1  serial DAC data, MSB first.
REQ-010 SHALL have port: i_adcdat  input  1  serial ADC data from the codec.
REQ-011 SHALL have port: o_linein  output  16  last captured left ADC word, two's complement.
REQ-012 SHALL have port: o_linein_valid  output  1  one-cycle strobe when o_linein updates.

Function
REQ-013 SHALL keep a 9-bit free-running frame counter cnt, incremented every clk24 and wrapping from 511 to 0 (one frame = 512 cycles, Fs = 46.875 kHz).
REQ-014 SHALL drive o_mclk = cnt[0], o_bck = cnt[2] and o_lrck = cnt[8], each taken directly from the counter register with no combinational decode.
REQ-015 SHALL define slot s = cnt[7:3] (0..31) within each channel half; BCK falls at the start of a slot and rises at cnt[2:0]=4.
REQ-016 SHALL, at the edge leaving cnt=511, latch i_sample_l and i_sample_r into shadow registers; o_sample_req SHALL be high exactly while cnt=511.
REQ-017 SHALL serialize only the shadow registers, so input changes inside a frame do not affect the frame in progress.
REQ-018 SHALL register o_dacdat at the edge leaving cnt[2:0]=7, so it changes together with the BCK falling edge.
REQ-019 SHALL make o_dacdat carry shadow bit (16-s) of the current channel during slots s=1..16 (I2S one-BCK delay), and 0 during slot 0 and slots 17..31.
REQ-020 SHALL sample i_adcdat at the edge leaving cnt[2:0]=3 (the BCK rising edge) during left-half slots 1..16, shifting MSB first into a 16-bit register.
REQ-021 SHALL transfer the shift register to o_linein at the edge leaving cnt=135; o_linein_valid SHALL be high exactly while cnt=136.
REQ-022 SHALL ignore right-half ADC data, and hold o_linein between updates.

Reset
REQ-023 SHALL, while reset is high, clear cnt, both shadow registers, the ADC shift register, o_dacdat, o_linein and o_linein_valid to 0; o_sample_req is 0 because cnt=0.
REQ-024 SHALL, on reset asserted mid-frame, abort the frame; the first post-reset frame transmits zeros, because the shadows are cleared.
REQ-025 SHALL, after reset deasserts, produce the first o_sample_req 511 cycles later and the first o_linein_valid 136 cycles later.

Configuration
REQ-026 SHALL honour the macro I2S_ADC_EN.
REQ-027 SHALL, when I2S_ADC_EN is defined, implement the ADC capture path per REQ-020..022.
REQ-028 SHALL, when I2S_ADC_EN is undefined, omit the capture logic, hold o_linein at 0 and o_linein_valid at 0, and leave i_adcdat unused; the DAC path is unchanged.

Verification
REQ-029 SHALL cover: release reset, hold inputs steady -> o_bck period 8 cycles, o_lrck period 512 cycles, o_sample_req high only at cnt=511.
REQ-030 SHALL cover: i_sample_l=16'hA55A, i_sample_r=16'h8001 -> next frame's left slots 1..16 carry 1010010101011010 and right slots 1..16 carry 1000000000000001; slots 0 and 17..31 carry 0.
REQ-031 SHALL cover: change i_sample_l from 16'h1234 to 16'hFFFF at cnt=200 -> current frame still sends 16'h1234; the next frame sends 16'hFFFF.
REQ-032 SHALL cover: codec model drives 16'hC3E1 in left slots 1..16 -> o_linein=16'hC3E1 with o_linein_valid high for 1 cycle at cnt=136; right-half data leaves o_linein unchanged.
REQ-033 SHALL cover: assert reset for 3 cycles at cnt=300 -> all outputs 0 during reset; the frame restarts at cnt=0 and its DAC data is all zeros.
REQ-034 SHALL cover: build without I2S_ADC_EN, toggle i_adcdat -> o_linein and o_linein_valid stay 0; the DAC waveform is identical to the enabled build.
